// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the tournament branch predictor.
// Counter helpers operate on a fixed-width container; callers pass their real width.
package bp_pkg;

  localparam int MAX_CTR_W = 8;
  localparam int BP_IDX_DEFAULT = 3;

  // Field layout of pred_info for the default IDX; the top slices by position for other IDX values.
  typedef struct packed {
    logic                      hit;
    logic                      take_l;
    logic                      take_g;
    logic                      sel_g;
    logic [BP_IDX_DEFAULT-1:0] ghr;
  } pred_info_t;

  function automatic logic [MAX_CTR_W-1:0] ctr_max(input int w);
    return MAX_CTR_W'((1 << w) - 1);
  endfunction

  function automatic logic [MAX_CTR_W-1:0] ctr_rst(input int w);
    return MAX_CTR_W'((1 << (w - 1)) - 1);
  endfunction

  function automatic logic [MAX_CTR_W-1:0] sat_inc(input logic [MAX_CTR_W-1:0] v, input int w);
    logic [MAX_CTR_W-1:0] m;
    m = ctr_max(w);
    return (v >= m) ? m : v + MAX_CTR_W'(1);
  endfunction

  function automatic logic [MAX_CTR_W-1:0] sat_dec(input logic [MAX_CTR_W-1:0] v, input int w);
    return (v == '0) ? '0 : v - MAX_CTR_W'(1);
  endfunction

  localparam logic [1:0] CTR_RST_W2 = 2'(ctr_rst(2));

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters: one combinational read port and one clocked
// saturating-update port. Reads see the pre-update value (no bypass).
module sat_counter_table
  import bp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int CTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  output logic [CTR_W-1:0]      rd_ctr_o,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_idx_i,
  input  logic                  wr_up_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CTR_W-1:0] RST_V = CTR_W'(ctr_rst(CTR_W));

  logic [CTR_W-1:0]     ctr_q [DEPTH];
  logic [CTR_W-1:0]     ctr_d;
  logic [MAX_CTR_W-1:0] cur_w;

  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_comb begin
    cur_w = MAX_CTR_W'(ctr_q[wr_idx_i]);
    ctr_d = wr_up_i ? CTR_W'(sat_inc(cur_w, CTR_W)) : CTR_W'(sat_dec(cur_w, CTR_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= RST_V;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/tournament_bp.sv
// Tournament branch predictor: local two-level + gshare + per-PC chooser,
// tagged BTB, speculative/committed global history and accuracy counters.
module tournament_bp
  import bp_pkg::*;
#(
  parameter int IDX      = 3,
  parameter int HIST_LEN = 3,
  parameter int CTR_W    = 2,
  parameter int BTB_IDX  = 6,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  output logic              pred_take,
  output logic [31:0]       pred_target,
  output logic [IDX+3:0]    pred_info,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic [IDX+3:0]    upd_info,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] perf_total,
  output logic [PERF_W-1:0] perf_correct,
  output logic [PERF_W-1:0] perf_wrong
);

  localparam int LHT_DEPTH = 1 << IDX;
  localparam int BTB_DEPTH = 1 << BTB_IDX;
  localparam int TAG_W     = 30 - BTB_IDX;
  localparam int HIT_B     = IDX + 3;
  localparam int TL_B      = IDX + 2;
  localparam int TG_B      = IDX + 1;

  logic [IDX-1:0]      pi, upi, gidx, upd_gidx;
  logic [IDX-1:0]      spec_ghr_q, spec_ghr_d, commit_ghr_q, commit_ghr_d;
  logic [HIST_LEN-1:0] lht_q [LHT_DEPTH];
  logic [HIST_LEN-1:0] lhist_rd, lhist_upd, lhist_d;
  logic [CTR_W-1:0]    lctr, gctr, cctr;

  logic                btb_valid_q [BTB_DEPTH];
  logic [TAG_W-1:0]    btb_tag_q   [BTB_DEPTH];
  logic [31:0]         btb_tgt_q   [BTB_DEPTH];
  logic [BTB_IDX-1:0]  bi, ubi;
  logic [TAG_W-1:0]    btag, ubtag;

  logic                hit, take_l, take_g, sel_g;
  logic                u_hit, u_take_l, u_take_g, restore;
  logic [IDX-1:0]      u_ghr;
  logic [PERF_W-1:0]   perf_total_q, perf_correct_q, perf_wrong_q;
  logic                unused_bits;

  assign pi    = if_pc[IDX+1:2];
  assign upi   = upd_pc[IDX+1:2];
  assign bi    = if_pc[BTB_IDX+1:2];
  assign btag  = if_pc[31:BTB_IDX+2];
  assign ubi   = upd_pc[BTB_IDX+1:2];
  assign ubtag = upd_pc[31:BTB_IDX+2];

  assign u_hit    = upd_info[HIT_B];
  assign u_take_l = upd_info[TL_B];
  assign u_take_g = upd_info[TG_B];
  assign u_ghr    = upd_info[IDX-1:0];

  assign lhist_rd  = lht_q[pi];
  assign lhist_upd = lht_q[upi];
  assign lhist_d   = {lhist_upd[HIST_LEN-2:0], upd_taken};
  assign gidx      = pi ^ spec_ghr_q;
  assign upd_gidx  = upi ^ u_ghr;

  sat_counter_table #(.DEPTH_LOG2(HIST_LEN), .CTR_W(CTR_W)) u_local_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx_i (lhist_rd),
    .rd_ctr_o (lctr),
    .wr_en_i  (upd_valid),
    .wr_idx_i (lhist_upd),
    .wr_up_i  (upd_taken)
  );

  sat_counter_table #(.DEPTH_LOG2(IDX), .CTR_W(CTR_W)) u_global_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx_i (gidx),
    .rd_ctr_o (gctr),
    .wr_en_i  (upd_valid),
    .wr_idx_i (upd_gidx),
    .wr_up_i  (upd_taken)
  );

  // Chooser only learns when the two components disagreed; up means global was right.
  sat_counter_table #(.DEPTH_LOG2(IDX), .CTR_W(CTR_W)) u_chooser (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx_i (pi),
    .rd_ctr_o (cctr),
    .wr_en_i  (upd_valid & (u_take_l ^ u_take_g)),
    .wr_idx_i (upi),
    .wr_up_i  (u_take_g == upd_taken)
  );

  assign take_l      = lctr[CTR_W-1];
  assign take_g      = gctr[CTR_W-1];
  assign sel_g       = cctr[CTR_W-1];
  assign hit         = btb_valid_q[bi] & (btb_tag_q[bi] == btag);
  assign pred_take   = hit & (sel_g ? take_g : take_l);
  assign pred_target = pred_take ? btb_tgt_q[bi] : if_pc + 32'd4;
  assign pred_info   = {hit, take_l, take_g, sel_g, spec_ghr_q};

  assign commit_ghr_d = {commit_ghr_q[IDX-2:0], upd_taken};
  assign restore      = upd_valid & (upd_mispredict | ~u_hit);

  always_comb begin
    spec_ghr_d = spec_ghr_q;
    if (restore) spec_ghr_d = commit_ghr_d;
    else if (if_valid & hit) spec_ghr_d = {spec_ghr_q[IDX-2:0], pred_take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LHT_DEPTH; i++) lht_q[i] <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
      spec_ghr_q     <= '0;
      commit_ghr_q   <= '0;
      perf_total_q   <= '0;
      perf_correct_q <= '0;
      perf_wrong_q   <= '0;
    end else begin
      spec_ghr_q <= spec_ghr_d;
      if (upd_valid) begin
        lht_q[upi]   <= lhist_d;
        commit_ghr_q <= commit_ghr_d;
        perf_total_q <= perf_total_q + PERF_W'(1);
        if (upd_mispredict) perf_wrong_q <= perf_wrong_q + PERF_W'(1);
        else                perf_correct_q <= perf_correct_q + PERF_W'(1);
        if (upd_taken) begin
          btb_valid_q[ubi] <= 1'b1;
          btb_tag_q[ubi]   <= ubtag;
          btb_tgt_q[ubi]   <= upd_target;
        end
      end
    end
  end

  assign perf_total   = perf_total_q;
  assign perf_correct = perf_correct_q;
  assign perf_wrong   = perf_wrong_q;

  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_info[IDX]};

endmodule

// File: tb/tb_tournament_bp.sv
// Self-checking bench for tournament_bp with a table-level reference model.
module tb_tournament_bp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_take;
  logic [31:0] pred_target;
  logic [6:0]  pred_info;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [6:0]  upd_info;
  logic        upd_mispredict;
  logic [31:0] perf_total, perf_correct, perf_wrong;

  int errors = 0;
  int checks = 0;

  tournament_bp dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc(if_pc),
    .pred_take(pred_take), .pred_target(pred_target), .pred_info(pred_info),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_info(upd_info), .upd_mispredict(upd_mispredict),
    .perf_total(perf_total), .perf_correct(perf_correct), .perf_wrong(perf_wrong)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer tables, counters 0..3, taken iff >= 2.
  int          m_lpht [8];
  int          m_gpht [8];
  int          m_ch   [8];
  int          m_lht  [8];
  bit          m_bv   [64];
  int unsigned m_btag [64];
  logic [31:0] m_btgt [64];
  int          m_spec, m_commit;
  int unsigned m_tot, m_cor, m_wrong;

  function automatic int sat(input int v, input bit up);
    if (up) return (v < 3) ? v + 1 : 3;
    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_lpht[i] = 1; m_gpht[i] = 1; m_ch[i] = 1; m_lht[i] = 0;
    end
    for (int i = 0; i < 64; i++) begin
      m_bv[i] = 1'b0; m_btag[i] = 0; m_btgt[i] = '0;
    end
    m_spec = 0; m_commit = 0; m_tot = 0; m_cor = 0; m_wrong = 0;
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit take,
                                    output logic [31:0] tgt, output logic [6:0] info);
    int p, b;
    bit h, tl, tg, sg;
    p  = int'((pc >> 2) & 32'h7);
    b  = int'((pc >> 2) & 32'h3f);
    h  = m_bv[b] && (m_btag[b] == (pc >> 8));
    tl = m_lpht[m_lht[p]] >= 2;
    tg = m_gpht[p ^ m_spec] >= 2;
    sg = m_ch[p] >= 2;
    take = h && (sg ? tg : tl);
    tgt  = take ? m_btgt[b] : pc + 32'd4;
    info = {h, tl, tg, sg, 3'(m_spec)};
  endfunction

  function automatic void m_update(input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                                   input logic [6:0] ui, input bit umis,
                                   input bit fv, input bit fhit, input bit ftake);
    int p, h, g, b, nc;
    p = int'((upc >> 2) & 32'h7);
    b = int'((upc >> 2) & 32'h3f);
    h = m_lht[p];
    m_lpht[h] = sat(m_lpht[h], ut);
    m_lht[p]  = ((h << 1) | int'(ut)) & 7;
    g = p ^ int'(ui[2:0]);
    m_gpht[g] = sat(m_gpht[g], ut);
    if (ui[5] != ui[4]) m_ch[p] = sat(m_ch[p], ui[4] == ut);
    if (ut) begin
      m_bv[b] = 1'b1; m_btag[b] = upc >> 8; m_btgt[b] = utgt;
    end
    nc = ((m_commit << 1) | int'(ut)) & 7;
    if (umis || !ui[6]) m_spec = nc;
    else if (fv && fhit) m_spec = ((m_spec << 1) | int'(ftake)) & 7;
    m_commit = nc;
    m_tot++;
    if (!umis) m_cor++;
    else m_wrong++;
  endfunction

  // Drive one cycle of inputs, clock it in, and advance the model by the same edge.
  task automatic do_cycle(input bit fv, input logic [31:0] fpc, input bit uv,
                          input logic [31:0] upc, input bit ut, input logic [31:0] utgt,
                          input logic [6:0] ui, input bit umis);
    bit ftake;
    logic [31:0] ftgt;
    logic [6:0] finfo;
    if_valid = fv; if_pc = fpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_info = ui; upd_mispredict = umis;
    m_predict(fpc, ftake, ftgt, finfo);
    @(posedge clk);
    if (uv) m_update(upc, ut, utgt, ui, umis, fv, finfo[6], ftake);
    else if (fv && finfo[6]) m_spec = ((m_spec << 1) | int'(ftake)) & 7;
    #1;
    upd_valid = 1'b0; if_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_valid = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_info = '0; upd_mispredict = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if_pc = 32'h100; #1;
    checks++;
    if (pred_take !== 1'b0) begin errors++; $display("FAIL reset_take: got %0b exp 0", pred_take); end
    checks++;
    if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_target: got %h exp 00000104", pred_target); end
    checks++;
    if (pred_info !== 7'd0) begin errors++; $display("FAIL reset_info: got %h exp 00", pred_info); end
    checks++;
    if ({perf_total, perf_correct, perf_wrong} !== 96'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d/%0d exp 0/0/0", perf_total, perf_correct, perf_wrong);
    end
  endtask

  task automatic test_btb_train();
    bit t; logic [31:0] tg; logic [6:0] inf;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m_predict(32'h100, t, tg, inf);
      do_cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h200, inf, k == 0);
    end
    if_pc = 32'h100; #1;
    m_predict(32'h100, t, tg, inf);
    checks++;
    if (pred_info[6] !== 1'b1) begin errors++; $display("FAIL train_hit: got %0b exp 1", pred_info[6]); end
    checks++;
    if (pred_take !== 1'b1) begin errors++; $display("FAIL train_take: got %0b exp 1", pred_take); end
    checks++;
    if (pred_target !== 32'h200) begin errors++; $display("FAIL train_target: got %h exp 00000200", pred_target); end
    checks++;
    if (pred_info !== inf) begin errors++; $display("FAIL train_info: got %h exp %h", pred_info, inf); end
    checks++;
    if (perf_total !== 32'd4) begin errors++; $display("FAIL train_total: got %0d exp 4", perf_total); end
    checks++;
    if (perf_correct !== 32'd3) begin errors++; $display("FAIL train_correct: got %0d exp 3", perf_correct); end
    checks++;
    if (perf_wrong !== 32'd1) begin errors++; $display("FAIL train_wrong: got %0d exp 1", perf_wrong); end
  endtask

  // Runs after test_btb_train: fetch of 0x100 hits and predicts taken.
  task automatic test_ghr_restore();
    bit t, ft; logic [31:0] tg; logic [6:0] inf, finf;
    int exp_ghr;
    m_predict(32'h100, ft, tg, finf);
    m_predict(32'h180, t, tg, inf);
    exp_ghr = ((m_commit << 1) | 0) & 7;
    if_pc = 32'h100; #1;
    checks++;
    if (pred_take !== ft) begin errors++; $display("FAIL ghr_pre_take: got %0b exp %0b", pred_take, ft); end
    do_cycle(1'b1, 32'h100, 1'b1, 32'h180, 1'b0, 32'h0, inf, 1'b1);
    #1;
    checks++;
    if (pred_info[2:0] !== 3'(exp_ghr)) begin
      errors++; $display("FAIL ghr_restore: got %0d exp %0d", pred_info[2:0], exp_ghr);
    end
    checks++;
    if (pred_info[2:0] !== 3'(m_spec)) begin
      errors++; $display("FAIL ghr_model: got %0d exp %0d", pred_info[2:0], m_spec);
    end
  endtask

  task automatic test_local_alternating();
    bit t, ut; logic [31:0] tg; logic [6:0] inf;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      ut = (k % 2) == 0;
      if_pc = 32'h108; #1;
      m_predict(32'h108, t, tg, inf);
      if (k >= 16) begin
        checks++;
        if (pred_info[5] !== ut) begin errors++; $display("FAIL alt_local: got %0b exp %0b", pred_info[5], ut); end
        checks++;
        if (pred_info !== inf) begin errors++; $display("FAIL alt_info: got %h exp %h", pred_info, inf); end
      end
      do_cycle(1'b0, 32'h108, 1'b1, 32'h108, ut, 32'h300, inf,
               (t != ut) || (ut && tg != 32'h300));
    end
  endtask

  task automatic test_btb_evict();
    bit t; logic [31:0] tg; logic [6:0] inf;
    do_reset();
    m_predict(32'h300, t, tg, inf);
    do_cycle(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'h500, inf, 1'b1);
    if_pc = 32'h300; #1;
    checks++;
    if (pred_info[6] !== 1'b1) begin errors++; $display("FAIL evict_first_hit: got %0b exp 1", pred_info[6]); end
    m_predict(32'h400, t, tg, inf);
    do_cycle(1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 32'h600, inf, 1'b1);
    if_pc = 32'h300; #1;
    checks++;
    if (pred_info[6] !== 1'b0) begin errors++; $display("FAIL evict_miss: got %0b exp 0", pred_info[6]); end
    checks++;
    if (pred_target !== 32'h304) begin errors++; $display("FAIL evict_target: got %h exp 00000304", pred_target); end
    if_pc = 32'h400; #1;
    checks++;
    if (pred_info[6] !== 1'b1) begin errors++; $display("FAIL evict_second_hit: got %0b exp 1", pred_info[6]); end
  endtask

  task automatic test_random();
    bit t, ut, uv, fv, mis; logic [31:0] tg, fpc, upc, utgt; logic [6:0] inf;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      fv  = $urandom_range(0, 1) == 1;
      fpc = 32'h1000 + ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 3) == 0) fpc = fpc + 32'h100;
      if_pc = fpc; #1;
      m_predict(fpc, t, tg, inf);
      checks++;
      if ({pred_take, pred_target, pred_info} !== {t, tg, inf}) begin
        errors++;
        $display("FAIL rand_pred pc=%h: got %0b/%h/%h exp %0b/%h/%h", fpc, pred_take, pred_target, pred_info, t, tg, inf);
      end
      checks++;
      if ({perf_total, perf_correct, perf_wrong} !== {m_tot, m_cor, m_wrong}) begin
        errors++;
        $display("FAIL rand_perf: got %0d/%0d/%0d exp %0d/%0d/%0d", perf_total, perf_correct, perf_wrong, m_tot, m_cor, m_wrong);
      end
      uv   = $urandom_range(0, 3) != 0;
      upc  = 32'h1000 + ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 3) == 0) upc = upc + 32'h100;
      ut   = $urandom_range(0, 1) == 1;
      utgt = 32'h8000 + ($urandom_range(0, 3) << 2);
      m_predict(upc, t, tg, inf);
      mis  = (t != ut) || (ut && tg != utgt);
      if ($urandom_range(0, 15) == 0) mis = !mis;
      do_cycle(fv, fpc, uv, upc, ut, utgt, inf, mis);
    end
  endtask

  task automatic test_async_reset();
    bit t; logic [31:0] tg; logic [6:0] inf;
    for (int k = 0; k < 4; k++) begin
      m_predict(32'h100, t, tg, inf);
      do_cycle(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, inf, 1'b0);
    end
    if_valid = 1'b1; if_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h200; upd_info = 7'h40; upd_mispredict = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    checks++;
    if ({pred_take, pred_target, pred_info} !== {1'b0, 32'h104, 7'h00}) begin
      errors++; $display("FAIL async_pred: got %0b/%h/%h exp 0/00000104/00", pred_take, pred_target, pred_info);
    end
    checks++;
    if ({perf_total, perf_correct, perf_wrong} !== 96'd0) begin
      errors++; $display("FAIL async_perf: got %0d/%0d/%0d exp 0/0/0", perf_total, perf_correct, perf_wrong);
    end
    #3 rst_n = 1'b1;
    m_predict(32'h100, t, tg, inf);
    do_cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, inf, 1'b1);
    checks++;
    if ({perf_total, perf_wrong} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL async_first_upd: got total=%0d wrong=%0d exp 1/1", perf_total, perf_wrong);
    end
    if_pc = 32'h100; #1;
    m_predict(32'h100, t, tg, inf);
    checks++;
    if ({pred_take, pred_target, pred_info} !== {t, tg, inf}) begin
      errors++; $display("FAIL async_after: got %0b/%h/%h exp %0b/%h/%h", pred_take, pred_target, pred_info, t, tg, inf);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_btb_train();
    test_ghr_restore();
    test_local_alternating();
    test_btb_evict();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
